vga_sync_gen: RTL and testbench

//  - 640x480@60 VGA timing generator; sits directly upstream of the pixel/pattern stage.
//  - Drives hsync/vsync to the DAC/connector.
//  - Drives display_on, pixel_x and pixel_y to the pattern stage, which colours each visible pixel.
//  - Runs on the 50 MHz board clock; an internal clock enable divides it down to a 25 MHz pixel rate.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_pixel_div.sv | 49 ++++
 rtl/vga_sync_gen.sv | 142 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared 640x480@60 timing constants, sync polarity, decode helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_LIMIT = 1 << COORD_W;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned VGA_CLK_DIV   = 2;
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Both syncs are active-low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{
    hsync:      ~SYNC_ACTIVE,
    vsync:      ~SYNC_ACTIVE,
    display_on: 1'b0
  };

  // True when val lies in the half-open window [lo, lo+len).
  function automatic logic in_span(
    input logic [COORD_W-1:0] val,
    input int unsigned        lo,
    input int unsigned        len
  );
    return (32'(val) >= lo) && (32'(val) < (lo + len));
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pixel_div.sv
// ============================================================================
// Module : vga_pixel_div
// Brief  : Board-clock to pixel-rate clock-enable generator (CLK_DIV clocks).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pixel_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick,
  output logic o_tick_nxt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;

  generate
    if (CLK_DIV <= 1) begin : g_div_one
      assign w_div_nxt = '0;
    end else begin : g_div_n
      assign w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
    end
  endgenerate

  // Tick is registered so it reads 0 while reset is held, even for CLK_DIV=1.
  assign o_tick_nxt = (w_div_nxt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_tick    <= o_tick_nxt;
    end
  end

  assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module : vga_sync_gen
// Brief  : 640x480@60 VGA timing generator; frame counter under VGA_FRAME_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK
) (
  input  logic               clock_50,
  input  logic               reset_n,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_tick,
  output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  generate
    if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit coordinate range");
    end
    if (CLK_DIV == 0) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
  endgenerate

  logic w_tick;
  logic w_tick_nxt;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_div (
    .clk        (clock_50),
    .rst_n      (reset_n),
    .o_tick     (w_tick),
    .o_tick_nxt (w_tick_nxt)
  );

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] w_h_nxt;
  logic [COORD_W-1:0] w_v_nxt;
  logic               w_h_wrap;
  logic               w_v_wrap;

  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);
    w_h_nxt  = r_h_cnt;
    w_v_nxt  = r_v_cnt;
    if (w_tick) begin
      if (w_h_wrap) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_wrap ? '0 : r_v_cnt + COORD_W'(1);
      end else begin
        w_h_nxt = r_h_cnt + COORD_W'(1);
      end
    end
  end

  // Decode from the next count so every registered output lines up with pixel_x/y.
  vga_ctrl_t w_ctrl_nxt;
  logic      w_frame_start_nxt;

  always_comb begin
    w_ctrl_nxt.display_on = in_span(w_h_nxt, 0, H_VISIBLE) &&
                            in_span(w_v_nxt, 0, V_VISIBLE);
    w_ctrl_nxt.hsync      = in_span(w_h_nxt, H_SYNC_START, H_SYNC) ?
                            SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_ctrl_nxt.vsync      = in_span(w_v_nxt, V_SYNC_START, V_SYNC) ?
                            SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_frame_start_nxt     = w_tick_nxt && (w_h_nxt == H_LAST) && (w_v_nxt == V_LAST);
  end

  vga_ctrl_t r_ctrl;
  logic      r_frame_start;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_ctrl        <= CTRL_IDLE;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_ctrl        <= w_ctrl_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign hsync       = r_ctrl.hsync;
  assign vsync       = r_ctrl.vsync;
  assign display_on  = r_ctrl.display_on;
  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign pixel_tick  = w_tick;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_count;

  // Steps on the same edge that wraps the counters back to (0,0).
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (r_frame_start) begin
      r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
    end
  end

  assign frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module : tb_vga_sync_gen
// Brief  : Directed self-checking bench for vga_sync_gen (full, small and CLK_DIV=1 timings).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic rst_f_n = 1'b0;
  logic rst_s_n = 1'b0;
  logic rst_d_n = 1'b0;

  logic       f_hs, f_vs, f_disp, f_tick, f_fs;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_disp, s_tick, s_fs;
  logic [9:0] s_x, s_y;
  logic       d_hs, d_vs, d_disp, d_tick, d_fs;
  logic [9:0] d_x, d_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] f_fc, s_fc, d_fc;
`endif

  vga_sync_gen u_full (
    .clock_50    (clk),
    .reset_n     (rst_f_n),
    .hsync       (f_hs),
    .vsync       (f_vs),
    .display_on  (f_disp),
    .pixel_x     (f_x),
    .pixel_y     (f_y),
    .pixel_tick  (f_tick),
    .frame_start (f_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (f_fc)
`endif
  );

  // Small timing: H 10/2/3/2 (17 total, sync x=12..14), V 6/2/2/3 (13 total, sync y=8..9).
  vga_sync_gen #(
    .CLK_DIV(2), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_small (
    .clock_50    (clk),
    .reset_n     (rst_s_n),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .display_on  (s_disp),
    .pixel_x     (s_x),
    .pixel_y     (s_y),
    .pixel_tick  (s_tick),
    .frame_start (s_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (s_fc)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_div1 (
    .clock_50    (clk),
    .reset_n     (rst_d_n),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .display_on  (d_disp),
    .pixel_x     (d_x),
    .pixel_y     (d_y),
    .pixel_tick  (d_tick),
    .frame_start (d_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (d_fc)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    rst_f_n = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({f_hs, f_vs, f_disp, f_tick, f_fs} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got hs/vs/disp/tick/fs=%b expected 11000",
               {f_hs, f_vs, f_disp, f_tick, f_fs});
    end
    n_tests++;
    if (f_x !== 10'd0 || f_y !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", f_x, f_y);
    end
    rst_f_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({f_disp, f_tick} !== 2'b11 || f_x !== 10'd0 || f_y !== 10'd0) begin
      n_fail++;
      $display("FAIL edge1: got disp=%b tick=%b (%0d,%0d) expected disp=1 tick=1 (0,0)",
               f_disp, f_tick, f_x, f_y);
    end
    @(negedge clk);
    n_tests++;
    if (f_x !== 10'd1 || f_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL edge2: got x=%0d tick=%b expected x=1 tick=0", f_x, f_tick);
    end
    @(negedge clk);
    n_tests++;
    if (f_x !== 10'd1 || f_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL edge3: got x=%0d tick=%b expected x=1 tick=1", f_x, f_tick);
    end
    @(negedge clk);
    n_tests++;
    if (f_x !== 10'd2 || f_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL edge4: got x=%0d tick=%b expected x=2 tick=0", f_x, f_tick);
    end
  endtask

  task automatic test_line_timing();
    int cyc      = 0;
    int ticks    = 0;
    int n_disp   = 0;
    int n_hs     = 0;
    int first_hs = -1;
    int seq_bad  = 0;
    bit found    = 1'b0;
    while (!found && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (f_tick && f_x == 10'd0 && f_y == 10'd1) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL line_start: got found=%b expected 1", found);
    end
    cyc = 0;
    while (found && ticks < 800 && cyc < 4000) begin
      if (f_tick) begin
        if (f_x !== 10'(ticks) || f_y !== 10'd1) seq_bad++;
        if (f_disp) n_disp++;
        if (!f_hs) begin
          n_hs++;
          if (first_hs < 0) first_hs = int'(f_x);
        end
        ticks++;
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (ticks !== 800 || seq_bad !== 0) begin
      n_fail++;
      $display("FAIL line_seq: got ticks=%0d bad=%0d expected ticks=800 bad=0", ticks, seq_bad);
    end
    n_tests++;
    if (n_disp !== 640) begin
      n_fail++;
      $display("FAIL line_display: got %0d expected 640", n_disp);
    end
    n_tests++;
    if (n_hs !== 96 || first_hs !== 656) begin
      n_fail++;
      $display("FAIL line_hsync: got len=%0d start=%0d expected len=96 start=656", n_hs, first_hs);
    end
    n_tests++;
    if (f_x !== 10'd0 || f_y !== 10'd2) begin
      n_fail++;
      $display("FAIL line_wrap: got (%0d,%0d) expected (0,2)", f_x, f_y);
    end
  endtask

  task automatic test_frame_timing();
    int  cyc = 0;
    bit  found = 1'b0;
    @(negedge clk);
    rst_s_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_s_n = 1'b1;
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_fs) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1 || s_tick !== 1'b1 || s_x !== 10'd16 || s_y !== 10'd12) begin
      n_fail++;
      $display("FAIL fs_position: got found=%b tick=%b (%0d,%0d) expected 1 1 (16,12)",
               found, s_tick, s_x, s_y);
    end
    @(negedge clk);
    n_tests++;
    if (s_fs !== 1'b0 || s_x !== 10'd0 || s_y !== 10'd0) begin
      n_fail++;
      $display("FAIL fs_wrap: got fs=%b (%0d,%0d) expected fs=0 (0,0)", s_fs, s_x, s_y);
    end
    for (int f = 0; f < 2; f++) begin
      int ticks = 0;
      int vs_n = 0;
      int vs_bad = 0;
      int disp_n = 0;
      int disp_bad = 0;
      int fs_n = 0;
      bit done = 1'b0;
      cyc = 0;
      while (!done && cyc < 1000) begin
        if (s_fs) fs_n++;
        if (s_tick) begin
          ticks++;
          if (!s_vs) begin
            vs_n++;
            if (s_y != 10'd8 && s_y != 10'd9) vs_bad++;
          end
          if (s_disp) begin
            disp_n++;
            if (s_y >= 10'd6) disp_bad++;
          end
          if (s_fs) done = 1'b1;
        end
        if (!done) begin
          @(negedge clk);
          cyc++;
        end
      end
      n_tests++;
      if (ticks !== 221) begin
        n_fail++;
        $display("FAIL frame%0d_ticks: got %0d expected 221", f, ticks);
      end
      n_tests++;
      if (vs_n !== 34 || vs_bad !== 0) begin
        n_fail++;
        $display("FAIL frame%0d_vsync: got ticks=%0d stray=%0d expected 34 0", f, vs_n, vs_bad);
      end
      n_tests++;
      if (disp_n !== 60 || disp_bad !== 0) begin
        n_fail++;
        $display("FAIL frame%0d_display: got n=%0d below=%0d expected 60 0", f, disp_n, disp_bad);
      end
      n_tests++;
      if (fs_n !== 1) begin
        n_fail++;
        $display("FAIL frame%0d_fs_width: got %0d clocks expected 1", f, fs_n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_frame_reset();
    int cyc = 0;
    bit found = 1'b0;
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_x == 10'd13 && s_y == 10'd8) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1 || {s_hs, s_vs} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_pre: got found=%b hs/vs=%b expected 1 00", found, {s_hs, s_vs});
    end
    #3;
    rst_s_n = 1'b0;
    #1;
    n_tests++;
    if ({s_hs, s_vs, s_disp, s_tick, s_fs} !== 5'b11000) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got hs/vs/disp/tick/fs=%b expected 11000",
               {s_hs, s_vs, s_disp, s_tick, s_fs});
    end
    n_tests++;
    if (s_x !== 10'd0 || s_y !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_xy: got (%0d,%0d) expected (0,0)", s_x, s_y);
    end
    @(negedge clk);
    rst_s_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (s_disp !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_resume: got disp=%b (%0d,%0d) expected 1 (0,0)", s_disp, s_x, s_y);
    end
  endtask

  task automatic test_clk_div1();
    int cyc = 0;
    int n_clk = 0;
    int tick_low = 0;
    int adv_bad = 0;
    bit found = 1'b0;
    bit done = 1'b0;
    logic [9:0] px, py, ex, ey;
    @(negedge clk);
    rst_d_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (d_tick !== 1'b1 || d_disp !== 1'b1 || d_x !== 10'd0 || d_y !== 10'd0) begin
      n_fail++;
      $display("FAIL div1_edge1: got tick=%b disp=%b (%0d,%0d) expected 1 1 (0,0)",
               d_tick, d_disp, d_x, d_y);
    end
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (d_fs) found = 1'b1;
    end
    n_tests++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL div1_fs: got found=%b expected 1", found);
    end
    px = d_x;
    py = d_y;
    while (found && !done && n_clk < 1000) begin
      @(negedge clk);
      n_clk++;
      if (!d_tick) tick_low++;
      ex = (px == 10'd16) ? 10'd0 : px + 10'd1;
      ey = (px != 10'd16) ? py : ((py == 10'd12) ? 10'd0 : py + 10'd1);
      if (d_x !== ex || d_y !== ey) adv_bad++;
      px = d_x;
      py = d_y;
      if (d_fs) done = 1'b1;
    end
    n_tests++;
    if (n_clk !== 221) begin
      n_fail++;
      $display("FAIL div1_frame_clocks: got %0d expected 221", n_clk);
    end
    n_tests++;
    if (tick_low !== 0 || adv_bad !== 0) begin
      n_fail++;
      $display("FAIL div1_advance: got tick_low=%0d bad_steps=%0d expected 0 0", tick_low, adv_bad);
    end
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic test_frame_count();
    int cyc;
    bit found;
    @(negedge clk);
    rst_s_n = 1'b0;
    @(negedge clk);
    rst_s_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (s_fc !== 16'd0) begin
      n_fail++;
      $display("FAIL fc_reset: got %0d expected 0", s_fc);
    end
    for (int k = 0; k < 3; k++) begin
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 1000) begin
        @(negedge clk);
        cyc++;
        if (s_fs) found = 1'b1;
      end
      n_tests++;
      if (found !== 1'b1 || s_fc !== 16'(k)) begin
        n_fail++;
        $display("FAIL fc_before%0d: got found=%b count=%0d expected 1 %0d", k, found, s_fc, k);
      end
      @(negedge clk);
      n_tests++;
      if (s_fc !== 16'(k + 1)) begin
        n_fail++;
        $display("FAIL fc_after%0d: got %0d expected %0d", k, s_fc, k + 1);
      end
    end
    force u_small.r_frame_count = 16'hFFFF;
    @(negedge clk);
    release u_small.r_frame_count;
    @(negedge clk);
    n_tests++;
    if (s_fc !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL fc_preload: got %h expected ffff", s_fc);
    end
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_fs) found = 1'b1;
    end
    @(negedge clk);
    n_tests++;
    if (found !== 1'b1 || s_fc !== 16'd0) begin
      n_fail++;
      $display("FAIL fc_wrap: got found=%b count=%h expected 1 0000", found, s_fc);
    end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_clk_div1();
`ifdef VGA_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
